step_pulse_gen: RTL

//  Stimulus-side partner of the step tracker: generates the STEP pulse train that the tracker counts.

---
 rtl/step_pulse_gen_pkg.sv | 27 ++
 rtl/step_pulse_gen_hybrid_rate_rom.sv | 33 +++
 rtl/step_pulse_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/step_pulse_gen_pkg.sv
// Shared codes for the step pulse generator: mode encodings, fixed rates,
// FSM states and the hybrid profile length.
package step_pulse_gen_pkg;

  localparam logic [1:0] MODE_WALK   = 2'd0;
  localparam logic [1:0] MODE_JOG    = 2'd1;
  localparam logic [1:0] MODE_RUN    = 2'd2;
  localparam logic [1:0] MODE_HYBRID = 2'd3;

  localparam logic [7:0] RATE_WALK = 8'd32;
  localparam logic [7:0] RATE_JOG  = 8'd64;
  localparam logic [7:0] RATE_RUN  = 8'd128;

  localparam logic [7:0] HYBRID_LAST_SEC = 8'd144;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/step_pulse_gen_hybrid_rate_rom.sv
// Hybrid profile: steps per second for a 1-based second index; zero outside
// the profile, which is what silences the generator once the profile ends.
module step_pulse_gen_hybrid_rate_rom
  import step_pulse_gen_pkg::*;
(
  input  logic [7:0] sec_idx,
  output logic [7:0] rate
);

  always_comb begin
    rate = 8'd0;
    case (sec_idx)
      8'd1:    rate = 8'd20;
      8'd2:    rate = 8'd33;
      8'd3:    rate = 8'd66;
      8'd4:    rate = 8'd27;
      8'd5:    rate = 8'd70;
      8'd6:    rate = 8'd30;
      8'd7:    rate = 8'd19;
      8'd8:    rate = 8'd30;
      8'd9:    rate = 8'd33;
      default: begin
        if (sec_idx >= 8'd10 && sec_idx <= 8'd73)
          rate = 8'd69;
        else if (sec_idx >= 8'd74 && sec_idx <= 8'd79)
          rate = 8'd34;
        else if (sec_idx >= 8'd80 && sec_idx <= HYBRID_LAST_SEC)
          rate = 8'd124;
      end
    endcase
  end

endmodule

// File: rtl/step_pulse_gen.sv
// STEP pulse train generator: fixed or scripted rate per second, steps spread
// evenly by a phase accumulator, plus a 1 s tick and elapsed-second count.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PULSE_W = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] MODE,
  output logic       STEP,
  output logic       SEC_TICK,
  output logic [7:0] ELAPSED,
  output logic       ACTIVE,
  output logic       DONE
);

  localparam int ACC_W = $clog2(CLK_HZ + 256);
  localparam int CNT_W = $clog2(CLK_HZ);
  localparam int PW_W  = $clog2(PULSE_W + 1);

  localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_HZ - 1);
  localparam logic [PW_W-1:0]  PW_RELOAD = PW_W'(PULSE_W - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       elapsed_q, elapsed_d;
  logic [7:0]       rate_q, rate_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic             step_q, step_d;

  logic             advance;
  logic             tick;
  logic             step_start;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       rom_idx;
  logic [7:0]       rom_rate;
  logic [7:0]       mode_rate;

  step_pulse_gen_hybrid_rate_rom u_rom (
    .sec_idx (rom_idx),
    .rate    (rom_rate)
  );

  // A RUN cycle with START low is already frozen, so a pause costs no extra cycle.
  always_comb begin
    advance    = (state_q == ST_RUN) && START;
    tick       = advance && (cnt_q == CNT_LAST);
    acc_sum    = acc_q + ACC_W'(rate_q);
    step_start = advance && (acc_sum >= ACC_LIMIT);
    elapsed_d  = tick ? sat_inc8(elapsed_q) : elapsed_q;
    // Rate for the second about to begin, numbered one past the completed count.
    rom_idx    = sat_inc8(elapsed_d);

    mode_rate = RATE_WALK;
    case (MODE)
      MODE_WALK:   mode_rate = RATE_WALK;
      MODE_JOG:    mode_rate = RATE_JOG;
      MODE_RUN:    mode_rate = RATE_RUN;
      MODE_HYBRID: mode_rate = rom_rate;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          rate_d  = mode_rate;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!START) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          cnt_d  = '0;
          acc_d  = '0;
          rate_d = mode_rate;
          if (MODE == MODE_HYBRID && elapsed_d >= HYBRID_LAST_SEC)
            state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = step_start ? acc_sum - ACC_LIMIT : acc_sum;
        end
      end
      ST_PAUSE: begin
        if (START)
          state_d = ST_RUN;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // Pulse timer runs in every state so a pulse cut by a pause still completes.
  always_comb begin
    pw_d   = '0;
    step_d = 1'b0;
    if (step_start) begin
      pw_d   = PW_RELOAD;
      step_d = 1'b1;
    end else if (pw_q != '0) begin
      pw_d   = pw_q - PW_W'(1);
      step_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      elapsed_q <= '0;
      rate_q    <= '0;
      pw_q      <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
      rate_q    <= rate_d;
      pw_q      <= pw_d;
      step_q    <= step_d;
    end
  end

  assign STEP     = step_q;
  assign SEC_TICK = tick;
  assign ELAPSED  = elapsed_q;
  assign ACTIVE   = (state_q == ST_RUN);
  assign DONE     = (state_q == ST_DONE);

endmodule
